// File: rtl/cart_dl_pkg.sv
// Shared types and header-checksum address constants for the cartridge download streamer.
package cart_dl_pkg;

  typedef enum logic [2:0] {
    IDLE, LO, HI, WR, GAP, HOLD, FIN, DONE
  } state_e;

  localparam logic [11:0] HDR_CSUM_FIRST = 12'h134;
  localparam logic [11:0] HDR_CSUM_LAST  = 12'h14C;
  localparam logic [11:0] HDR_CSUM_BYTE  = 12'h14D;

endpackage

// File: rtl/cart_dl_streamer_hdr.sv
// Cartridge header checksum over bytes 0x134..0x14C, compared at FIN against byte 0x14D.
// Only built when CART_DL_HDR_CHECK_EN is defined.
`ifdef CART_DL_HDR_CHECK_EN
module cart_hdr_checksum
  import cart_dl_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        byte_stb_i,
  input  logic [31:0] byte_addr_i,
  input  logic [7:0]  data_i,
  input  logic        fin_i,
  output logic        hdr_ok_o
);

  logic [7:0] x_q;
  logic [7:0] ref_q;
  logic       seen_q;
  logic       hdr_ok_q;

  assign hdr_ok_o = hdr_ok_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      x_q      <= 8'h00;
      ref_q    <= 8'h00;
      seen_q   <= 1'b0;
      hdr_ok_q <= 1'b0;
    end else if (clear_i) begin
      x_q      <= 8'h00;
      seen_q   <= 1'b0;
      hdr_ok_q <= 1'b0;
    end else begin
      if (byte_stb_i) begin
        if (byte_addr_i >= 32'(HDR_CSUM_FIRST) && byte_addr_i <= 32'(HDR_CSUM_LAST))
          x_q <= x_q - data_i - 8'd1;
        if (byte_addr_i == 32'(HDR_CSUM_BYTE)) begin
          ref_q  <= data_i;
          seen_q <= 1'b1;
        end
      end
      // A short image never delivers the reference byte, so it fails.
      if (fin_i)
        hdr_ok_q <= seen_q && (x_q == ref_q);
    end
  end

endmodule
`endif

// File: rtl/cart_dl_streamer.sv
// Byte-stream to 16-bit ioctl word packer for cartridge ROM download, paced by ioctl_wait.
// Optional header checksum output hdr_ok when CART_DL_HDR_CHECK_EN is defined.
module cart_dl_streamer
  import cart_dl_pkg::*;
#(
  parameter int          ADDR_W    = 25,
  parameter logic [31:0] MAX_BYTES = 32'h800000,
  parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              src_valid,
  input  logic [7:0]        src_data,
  input  logic              src_last,
  output logic              src_ready,
  output logic              cart_download,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [15:0]       ioctl_dout,
  input  logic              ioctl_wait,
  output logic [63:0]       img_size,
  output logic              done,
`ifdef CART_DL_HDR_CHECK_EN
  output logic              hdr_ok,
`endif
  output logic              overflow
);

  state_e            state_q;
  logic [31:0]       cnt_q;
  logic [15:0]       data_q;
  logic [ADDR_W-1:0] waddr_q;
  logic              last_q;
  logic              dl_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       dout_q;
  logic [63:0]       size_q;
  logic              done_q;
  logic              ovf_q;

  logic sat;
  logic active;
  logic launch;
  logic take;

  assign src_ready = (state_q == LO) || (state_q == HI);
  assign sat       = (cnt_q == MAX_BYTES);
  assign active    = src_ready || (state_q == WR) || (state_q == GAP) || (state_q == HOLD);
  assign launch    = start && !abort && ((state_q == IDLE) || (state_q == DONE));
  assign take      = src_valid && src_ready;

  assign cart_download = dl_q;
  assign ioctl_wr      = wr_q;
  assign ioctl_addr    = addr_q;
  assign ioctl_dout    = dout_q;
  assign img_size      = size_q;
  assign done          = done_q;
  assign overflow      = ovf_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      data_q  <= 16'h0000;
      waddr_q <= '0;
      last_q  <= 1'b0;
      dl_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= 16'h0000;
      size_q  <= 64'd0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      if (take && !sat)
        cnt_q <= cnt_q + 32'd1;
      case (state_q)
        IDLE, DONE: begin
          if (launch) begin
            state_q <= LO;
            dl_q    <= 1'b1;
            cnt_q   <= 32'd0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            waddr_q <= '0;
            last_q  <= 1'b0;
          end
        end
        LO: begin
          if (src_valid) begin
            // Past the size limit bytes are drained but never written.
            if (sat) begin
              ovf_q <= 1'b1;
              if (src_last)
                state_q <= FIN;
            end else begin
              data_q[7:0] <= src_data;
              last_q      <= src_last;
              if (src_last) begin
                data_q[15:8] <= FILL_BYTE;
                state_q      <= WR;
              end else begin
                state_q <= HI;
              end
            end
          end
        end
        HI: begin
          if (src_valid) begin
            last_q  <= src_last;
            state_q <= WR;
            if (sat) begin
              ovf_q        <= 1'b1;
              data_q[15:8] <= FILL_BYTE;
            end else begin
              data_q[15:8] <= src_data;
            end
          end
        end
        WR: begin
          wr_q    <= 1'b1;
          addr_q  <= waddr_q;
          dout_q  <= data_q;
          state_q <= GAP;
        end
        GAP: state_q <= HOLD;
        HOLD: begin
          if (!ioctl_wait) begin
            if (last_q) begin
              state_q <= FIN;
            end else begin
              waddr_q <= waddr_q + ADDR_W'(2);
              state_q <= LO;
            end
          end
        end
        FIN: begin
          dl_q    <= 1'b0;
          size_q  <= {32'd0, cnt_q};
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
      // Abort drops any half word and suppresses a write not yet strobed.
      if (abort && active) begin
        state_q <= FIN;
        wr_q    <= 1'b0;
      end
    end
  end

`ifdef CART_DL_HDR_CHECK_EN
  cart_hdr_checksum u_hdr (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .clear_i     (launch),
    .byte_stb_i  (take && !sat),
    .byte_addr_i (cnt_q),
    .data_i      (src_data),
    .fin_i       (state_q == FIN),
    .hdr_ok_o    (hdr_ok)
  );
`endif

endmodule

// File: tb/tb_cart_dl_streamer.sv
// Randomised bench for cart_dl_streamer against a byte-list reference model of the expected writes.
// Header checksum scenario runs only when CART_DL_HDR_CHECK_EN is defined.
module tb_cart_dl_streamer;
  localparam int ADDR_W = 25;
  localparam int BIG    = 32'h800000;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, abort = 1'b0;
  logic src_valid = 1'b0, src_last = 1'b0;
  logic [7:0] src_data = 8'h00;
  logic ioctl_wait = 1'b0;

  logic rdy_a, dl_a, wr_a, done_a, ovf_a;
  logic rdy_b, dl_b, wr_b, done_b, ovf_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [15:0] dout_a, dout_b;
  logic [63:0] size_a, size_b;
`ifdef CART_DL_HDR_CHECK_EN
  logic hdr_a, hdr_b;
`endif

  always #5 clk_sys = ~clk_sys;

  cart_dl_streamer dut_a (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start_a), .abort(abort),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(rdy_a),
    .cart_download(dl_a), .ioctl_wr(wr_a), .ioctl_addr(addr_a), .ioctl_dout(dout_a),
    .ioctl_wait(ioctl_wait), .img_size(size_a), .done(done_a),
`ifdef CART_DL_HDR_CHECK_EN
    .hdr_ok(hdr_a),
`endif
    .overflow(ovf_a));

  cart_dl_streamer #(.MAX_BYTES(32'd8)) dut_b (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start_b), .abort(abort),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(rdy_b),
    .cart_download(dl_b), .ioctl_wr(wr_b), .ioctl_addr(addr_b), .ioctl_dout(dout_b),
    .ioctl_wait(ioctl_wait), .img_size(size_b), .done(done_b),
`ifdef CART_DL_HDR_CHECK_EN
    .hdr_ok(hdr_b),
`endif
    .overflow(ovf_b));

  logic sel = 1'b0;
  logic rdy, dl, wr, done, ovf;
  logic [ADDR_W-1:0] addr;
  logic [15:0] dout;
  logic [63:0] size;
  always_comb begin
    rdy  = sel ? rdy_b  : rdy_a;
    dl   = sel ? dl_b   : dl_a;
    wr   = sel ? wr_b   : wr_a;
    done = sel ? done_b : done_a;
    ovf  = sel ? ovf_b  : ovf_a;
    addr = sel ? addr_b : addr_a;
    dout = sel ? dout_b : dout_a;
    size = sel ? size_b : size_a;
  end

  // Cartridge model: busy for wait_len cycles starting the cycle after each write strobe.
  int wait_len = 0;
  int wleft = 0;
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ioctl_wait <= 1'b0;
      wleft      <= 0;
    end else if (wr && wait_len > 0) begin
      ioctl_wait <= 1'b1;
      wleft      <= wait_len - 1;
    end else if (wleft > 0) begin
      wleft <= wleft - 1;
    end else begin
      ioctl_wait <= 1'b0;
    end
  end

  logic [ADDR_W-1:0] got_addr[$];
  logic [15:0]       got_data[$];
  int viol = 0;
  always @(negedge clk_sys) begin
    if (reset_n && wr) begin
      got_addr.push_back(addr);
      got_data.push_back(dout);
      if (ioctl_wait) viol++;
    end
  end

  int checks = 0;
  int errors = 0;

  logic [7:0]        img[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [15:0]       exp_data[$];

  // Expected word list: the first n_keep bytes paired little-endian, odd tail padded with FF.
  function automatic void build_exp(input int n_keep);
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < n_keep; i += 2) begin
      exp_addr.push_back(ADDR_W'(i));
      exp_data.push_back({(i + 1 < n_keep) ? img[i+1] : 8'hFF, img[i]});
    end
  endfunction

  task automatic make_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(8'($urandom_range(255)));
  endtask

  task automatic pulse_start();
    @(negedge clk_sys);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk_sys);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send_bytes(input int from, input int to, input int gap_pct);
    int t;
    for (int i = from; i < to; i++) begin
      for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
        src_valid = 1'b0;
        @(negedge clk_sys);
      end
      src_valid = 1'b1;
      src_data  = img[i];
      src_last  = (i == img.size() - 1);
      t = 0;
      while (!rdy && t < 200) begin @(negedge clk_sys); t++; end
      if (!rdy) begin
        checks++; errors++;
        $display("FAIL src_ready_timeout byte %0d got ready=0 exp ready=1", i);
        src_valid = 1'b0;
        src_last  = 1'b0;
        return;
      end
      @(negedge clk_sys);
    end
    src_valid = 1'b0;
    src_last  = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 500) begin @(negedge clk_sys); t++; end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout got done=0 exp done=1");
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({rdy_a, dl_a, wr_a, done_a, ovf_a, addr_a, dout_a} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %0h exp 0", {rdy_a, dl_a, wr_a, done_a, ovf_a, addr_a, dout_a});
    end
    checks++;
    if (size_a !== 64'd0) begin errors++; $display("FAIL reset_size got %0d exp 0", size_a); end
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic test_fixed();
    int base, n;
    for (int k = 0; k < 2; k++) begin
      img.delete();
      if (k == 0) begin
        img.push_back(8'h00); img.push_back(8'hC3); img.push_back(8'h50); img.push_back(8'h01);
      end else begin
        img.push_back(8'hAA); img.push_back(8'hBB); img.push_back(8'hCC);
      end
      sel = 1'b0; wait_len = 0; base = got_addr.size();
      pulse_start();
      send_bytes(0, img.size(), 0);
      wait_done();
      build_exp(img.size());
      n = got_addr.size() - base;
      checks++;
      if (n !== exp_addr.size()) begin errors++; $display("FAIL fixed%0d_wr_count got %0d exp %0d", k, n, exp_addr.size()); end
      for (int i = 0; i < n && i < exp_addr.size(); i++) begin
        checks++;
        if ({got_addr[base+i], got_data[base+i]} !== {exp_addr[i], exp_data[i]}) begin
          errors++;
          $display("FAIL fixed%0d_word%0d got %0h/%0h exp %0h/%0h", k, i, got_addr[base+i], got_data[base+i], exp_addr[i], exp_data[i]);
        end
      end
      checks++;
      if (size !== 64'(img.size())) begin errors++; $display("FAIL fixed%0d_size got %0d exp %0d", k, size, img.size()); end
      checks++;
      if ({done, ovf, dl} !== 3'b100) begin errors++; $display("FAIL fixed%0d_flags got %b exp 100", k, {done, ovf, dl}); end
    end
  endtask

  task automatic test_wait();
    int base, n, v0;
    make_img(32);
    sel = 1'b0; wait_len = 2; base = got_addr.size(); v0 = viol;
    pulse_start();
    send_bytes(0, 32, 30);
    wait_done();
    build_exp(32);
    n = got_addr.size() - base;
    checks++;
    if (n !== 16) begin errors++; $display("FAIL wait_wr_count got %0d exp 16", n); end
    for (int i = 0; i < n && i < exp_addr.size(); i++) begin
      checks++;
      if ({got_addr[base+i], got_data[base+i]} !== {exp_addr[i], exp_data[i]}) begin
        errors++;
        $display("FAIL wait_word%0d got %0h/%0h exp %0h/%0h", i, got_addr[base+i], got_data[base+i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (viol !== v0) begin errors++; $display("FAIL wait_wr_while_busy got %0d exp 0", viol - v0); end
    wait_len = 0;
  endtask

  task automatic test_overflow();
    int base, n;
    make_img(10);
    sel = 1'b1; wait_len = $urandom_range(3); base = got_addr.size();
    pulse_start();
    send_bytes(0, 10, 20);
    wait_done();
    build_exp(8);
    n = got_addr.size() - base;
    checks++;
    if (n !== 4) begin errors++; $display("FAIL ovf_wr_count got %0d exp 4", n); end
    for (int i = 0; i < n && i < exp_addr.size(); i++) begin
      checks++;
      if ({got_addr[base+i], got_data[base+i]} !== {exp_addr[i], exp_data[i]}) begin
        errors++;
        $display("FAIL ovf_word%0d got %0h/%0h exp %0h/%0h", i, got_addr[base+i], got_data[base+i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if ({size, ovf, done} !== {64'd8, 2'b11}) begin errors++; $display("FAIL ovf_result got size=%0d ovf=%b done=%b exp 8 1 1", size, ovf, done); end
    sel = 1'b0; wait_len = 0;
  endtask

  task automatic test_abort();
    int base, n;
    make_img(9);
    sel = 1'b0; wait_len = $urandom_range(2); base = got_addr.size();
    pulse_start();
    send_bytes(0, 5, 20);
    abort = 1'b1;
    @(negedge clk_sys);
    abort = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (dl !== 1'b0) begin errors++; $display("FAIL abort_download_drop got %b exp 0", dl); end
    wait_done();
    build_exp(4);
    n = got_addr.size() - base;
    checks++;
    if (n !== 2) begin errors++; $display("FAIL abort_wr_count got %0d exp 2", n); end
    for (int i = 0; i < n && i < exp_addr.size(); i++) begin
      checks++;
      if ({got_addr[base+i], got_data[base+i]} !== {exp_addr[i], exp_data[i]}) begin
        errors++;
        $display("FAIL abort_word%0d got %0h/%0h exp %0h/%0h", i, got_addr[base+i], got_data[base+i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (size !== 64'd5) begin errors++; $display("FAIL abort_size got %0d exp 5", size); end
    // zero-length image
    base = got_addr.size();
    pulse_start();
    abort = 1'b1;
    @(negedge clk_sys);
    abort = 1'b0;
    wait_done();
    checks++;
    if ({size, done, dl} !== {64'd0, 2'b10} || got_addr.size() != base) begin
      errors++;
      $display("FAIL zero_len got size=%0d done=%b dl=%b writes=%0d exp 0 1 0 0", size, done, dl, got_addr.size() - base);
    end
  endtask

  task automatic test_start_ctl();
    int base, n;
    @(negedge clk_sys);
    start_a = 1'b1; abort = 1'b1;
    @(negedge clk_sys);
    start_a = 1'b0; abort = 1'b0;
    checks++;
    if ({done, dl} !== 2'b10) begin errors++; $display("FAIL start_abort_together got done=%b dl=%b exp 1 0", done, dl); end
    make_img(8);
    base = got_addr.size();
    pulse_start();
    send_bytes(0, 3, 0);
    pulse_start();
    send_bytes(3, 8, 0);
    wait_done();
    build_exp(8);
    n = got_addr.size() - base;
    checks++;
    if (n !== 4 || size !== 64'd8) begin errors++; $display("FAIL start_ignored got writes=%0d size=%0d exp 4 8", n, size); end
    for (int i = 0; i < n && i < exp_addr.size(); i++) begin
      checks++;
      if ({got_addr[base+i], got_data[base+i]} !== {exp_addr[i], exp_data[i]}) begin
        errors++;
        $display("FAIL restart_word%0d got %0h/%0h exp %0h/%0h", i, got_addr[base+i], got_data[base+i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_random();
    int base, n, len, keep, v0;
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 40);
      make_img(len);
      sel = 1'($urandom_range(1));
      wait_len = $urandom_range(3);
      keep = (sel && len > 8) ? 8 : len;
      base = got_addr.size(); v0 = viol;
      pulse_start();
      send_bytes(0, len, 25);
      wait_done();
      build_exp(keep);
      n = got_addr.size() - base;
      checks++;
      if (n !== exp_addr.size()) begin errors++; $display("FAIL rnd%0d_wr_count got %0d exp %0d", r, n, exp_addr.size()); end
      for (int i = 0; i < n && i < exp_addr.size(); i++) begin
        checks++;
        if ({got_addr[base+i], got_data[base+i]} !== {exp_addr[i], exp_data[i]}) begin
          errors++;
          $display("FAIL rnd%0d_word%0d got %0h/%0h exp %0h/%0h", r, i, got_addr[base+i], got_data[base+i], exp_addr[i], exp_data[i]);
        end
      end
      checks++;
      if ({size, ovf, dl} !== {64'(keep), (len > keep), 1'b0} || viol != v0) begin
        errors++;
        $display("FAIL rnd%0d_result got size=%0d ovf=%b dl=%b busywr=%0d exp %0d %b 0 0", r, size, ovf, dl, viol - v0, keep, len > keep);
      end
    end
    sel = 1'b0; wait_len = 0;
  endtask

  task automatic test_reset_mid();
    make_img(12);
    sel = 1'b0; wait_len = 2;
    pulse_start();
    send_bytes(0, 5, 0);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rdy_a, dl_a, wr_a, done_a, ovf_a, addr_a, dout_a, size_a} !== '0) begin
      errors++;
      $display("FAIL reset_mid got %0h exp 0", {rdy_a, dl_a, wr_a, done_a, ovf_a, addr_a, dout_a, size_a});
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    wait_len = 0;
    @(negedge clk_sys);
  endtask

`ifdef CART_DL_HDR_CHECK_EN
  task automatic test_hdr();
    logic [7:0] x;
    logic expv;
    for (int k = 0; k < 2; k++) begin
      make_img(32'h150);
      x = 8'h00;
      for (int a = 32'h134; a <= 32'h14C; a++) x = x - img[a] - 8'd1;
      img[32'h14D] = (k == 0) ? x : ~x;
      expv = (img[32'h14D] == x);
      sel = 1'b0;
      pulse_start();
      send_bytes(0, img.size(), 10);
      wait_done();
      checks++;
      if (hdr_a !== expv) begin errors++; $display("FAIL hdr_ok_%0d got %b exp %b", k, hdr_a, expv); end
    end
  endtask
`endif

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fixed();
    test_wait();
    test_overflow();
    test_abort();
    test_start_ctl();
    test_random();
    test_reset_mid();
`ifdef CART_DL_HDR_CHECK_EN
    test_hdr();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
